// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: WASD direction encodings, Set-2 scan codes and transmitter state types.
// The direction and scan-code constants are also used by the receive-side mapper.
package ps2_pkg;

    localparam logic [3:0] DIRECTION_UP    = 4'b0001;
    localparam logic [3:0] DIRECTION_DOWN  = 4'b0010;
    localparam logic [3:0] DIRECTION_RIGHT = 4'b0100;
    localparam logic [3:0] DIRECTION_LEFT  = 4'b1000;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    // Keystroke-level states owned by the top level.
    typedef enum logic [1:0] {
        StIdle,
        StFrame,
        StGap
    } tx_state_e;

    // Bit-level states owned by the frame serializer.
    typedef enum logic [1:0] {
        StFrIdle,
        StBitHi,
        StBitLo
    } frame_state_e;

    function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

    function automatic logic [7:0] dir_to_scan(logic [3:0] dir);
        logic [7:0] code;
        case (dir)
            DIRECTION_UP:    code = SC_W;
            DIRECTION_DOWN:  code = SC_S;
            DIRECTION_RIGHT: code = SC_D;
            DIRECTION_LEFT:  code = SC_A;
            default:         code = 8'h00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ps2_key_encoder_tx_if.sv
// Command handshake and PS/2 line bundle between a command source and the keyboard emulator.
interface ps2_key_encoder_tx_if;

    logic [3:0] key_command;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;

    modport master (
        output key_command,
        output cmd_valid,
        input  cmd_ready,
        input  ps2_clk,
        input  ps2_data,
        input  busy
    );

    modport slave (
        input  key_command,
        input  cmd_valid,
        output cmd_ready,
        output ps2_clk,
        output ps2_data,
        output busy
    );

endinterface

// File: rtl/ps2_frame_tx.sv
// Serializes one byte as an 11-bit PS/2 device frame: start 0, 8 data bits LSB first,
// odd parity, stop 1. Each bit is driven while ps2_clk is high and held through the low half.
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HALF = 2500,
    parameter int unsigned CNT_W    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       done,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam logic [CNT_W-1:0] HalfLast = CNT_W'(CLK_HALF - 1);
    localparam logic [3:0]       LastBit  = 4'd10;

    frame_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [10:0]      shift_q, shift_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFrIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        done     = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        unique case (state_q)
            StFrIdle: begin
                cnt_d = '0;
                if (start) begin
                    state_d = StBitHi;
                    bit_d   = '0;
                    shift_d = {1'b1, ~^tx_byte, tx_byte, 1'b0};
                end
            end
            StBitHi: begin
                ps2_data = shift_q[0];
                if (cnt_q == HalfLast) begin
                    state_d = StBitLo;
                    cnt_d   = '0;
                end
            end
            StBitLo: begin
                ps2_clk  = 1'b0;
                ps2_data = shift_q[0];
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (bit_q == LastBit) begin
                        state_d = StFrIdle;
                        done    = 1'b1;
                    end else begin
                        // Data only moves on entry to the high half, so the host sees it stable.
                        state_d = StBitHi;
                        bit_d   = bit_q + 4'd1;
                        shift_d = {1'b1, shift_q[10:1]};
                    end
                end
            end
            default: begin
                state_d = StFrIdle;
            end
        endcase
    end

endmodule

// File: rtl/ps2_key_encoder_tx.sv
// Keyboard emulator for the WASD path: turns a one-hot direction into a full Set-2 keystroke
// (make code, 0xF0, make code) with an idle gap after every byte.
module ps2_key_encoder_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HALF   = 2500,
    parameter int unsigned GAP_CYCLES = 5000
) (
    input logic                 clk,
    input logic                 rst,
    ps2_key_encoder_tx_if.slave bus
);

    localparam int unsigned      CNT_W   = cnt_width(CLK_HALF, GAP_CYCLES);
    localparam logic [CNT_W-1:0] GapLast = CNT_W'(GAP_CYCLES - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       code_q, code_d;

    logic       start;
    logic [7:0] tx_byte;
    logic       frame_done;
    logic       cmd_onehot;
    logic [7:0] cmd_code;

    assign cmd_onehot = $onehot(bus.key_command);
    assign cmd_code   = dir_to_scan(bus.key_command);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gap_cnt_q  <= '0;
            byte_idx_q <= '0;
            code_q     <= '0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            byte_idx_q <= byte_idx_d;
            code_q     <= code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = '0;
        byte_idx_d = byte_idx_q;
        code_d     = code_q;
        start      = 1'b0;
        tx_byte    = code_q;
        unique case (state_q)
            StIdle: begin
                // Non-one-hot commands are consumed here without leaving idle.
                if (bus.cmd_valid && cmd_onehot) begin
                    state_d    = StFrame;
                    byte_idx_d = 2'd0;
                    code_d     = cmd_code;
                    start      = 1'b1;
                    tx_byte    = cmd_code;
                end
            end
            StFrame: begin
                if (frame_done) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q + CNT_W'(1);
                if (gap_cnt_q == GapLast) begin
                    gap_cnt_d = '0;
                    if (byte_idx_q == 2'd2) begin
                        state_d = StIdle;
                    end else begin
                        state_d    = StFrame;
                        byte_idx_d = byte_idx_q + 2'd1;
                        start      = 1'b1;
                        tx_byte    = (byte_idx_q == 2'd0) ? SC_BREAK : code_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);

    ps2_frame_tx #(
        .CLK_HALF (CLK_HALF),
        .CNT_W    (CNT_W)
    ) u_frame_tx (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tx_byte  (tx_byte),
        .done     (frame_done),
        .ps2_clk  (bus.ps2_clk),
        .ps2_data (bus.ps2_data)
    );

endmodule

// File: tb/tb_ps2_key_encoder_tx.sv
// Bench for ps2_key_encoder_tx: timeline model of a keystroke checked every cycle, plus a
// falling-edge PS/2 receiver that decodes frames against the expected byte stream.
module tb_ps2_key_encoder_tx;

    localparam int CH    = 4;
    localparam int GAP   = 10;
    localparam int FRAME = 22 * CH;
    localparam int PER   = FRAME + GAP;
    localparam int TOTAL = 3 * PER;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ps2_key_encoder_tx_if bus ();

    ps2_key_encoder_tx #(
        .CLK_HALF   (CH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] scan_of(input logic [3:0] k);
        case (k)
            4'b0001: return 8'h1D;
            4'b0010: return 8'h1B;
            4'b0100: return 8'h23;
            4'b1000: return 8'h1C;
            default: return 8'h00;
        endcase
    endfunction

    // Bit i of the transmitted frame for byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9) return ~^b;
        return 1'b1;
    endfunction

    // Timeline model: m_k is the cycle offset into the active keystroke.
    logic        m_active = 1'b0;
    int          m_k      = 0;
    logic [7:0]  m_code   = 8'h00;
    logic [7:0]  exp_q[$];
    logic [10:0] frames[$];
    int          rx_n     = 0;
    logic [10:0] rx_bits  = '0;
    logic        rx_en    = 1'b0;
    int          busy_cnt = 0;

    always @(negedge clk) begin : model
        logic [3:0] exp_o;
        int         r;
        int         bi;
        logic [7:0] b;
        if (!m_active) begin
            exp_o = 4'b1011;
        end else begin
            r  = m_k % PER;
            bi = m_k / PER;
            b  = (bi == 1) ? 8'hF0 : m_code;
            if (r < FRAME) begin
                exp_o[3] = 1'b0;
                exp_o[2] = 1'b1;
                exp_o[1] = ((r % (2 * CH)) < CH);
                exp_o[0] = frame_bit(b, r / (2 * CH));
            end else begin
                exp_o = 4'b0111;
            end
        end
        check("ready_busy_clk_data", {bus.cmd_ready, bus.busy, bus.ps2_clk, bus.ps2_data}, exp_o);
        if (bus.busy) busy_cnt++;
        if (rst) begin
            m_active = 1'b0;
            exp_q.delete();
            rx_n = 0;
        end else if (m_active) begin
            m_k++;
            if (m_k == TOTAL) m_active = 1'b0;
        end else if (bus.cmd_valid && $countones(bus.key_command) == 1) begin
            m_active = 1'b1;
            m_k      = 0;
            m_code   = scan_of(bus.key_command);
            exp_q.push_back(m_code);
            exp_q.push_back(8'hF0);
            exp_q.push_back(m_code);
        end
    end

    // Host-side receiver: samples data on each falling ps2_clk edge.
    always @(negedge bus.ps2_clk) begin
        if (rx_en) begin
            rx_bits[rx_n] = bus.ps2_data;
            rx_n++;
            if (rx_n == 11) begin
                rx_n = 0;
                frames.push_back(rx_bits);
                check("rx_start", rx_bits[0], 1'b0);
                check("rx_stop", rx_bits[10], 1'b1);
                check("rx_parity", rx_bits[9], ~^rx_bits[8:1]);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_byte: got %02h want none", rx_bits[8:1]);
                end else begin
                    check("rx_byte", rx_bits[8:1], exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [3:0] k, input int len);
        @(posedge clk);
        #1;
        bus.key_command = k;
        bus.cmd_valid   = 1'b1;
        repeat (len) @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(bus.cmd_ready && !bus.busy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", {bus.cmd_ready, bus.busy}, 2'b10);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int f0;
        int n;
        logic [3:0] k;
        bus.key_command = 4'b0000;
        bus.cmd_valid   = 1'b0;
        cycles(3);
        rst   = 1'b0;
        rx_en = 1'b1;
        cycles(2);
        check("reset_outputs", {bus.cmd_ready, bus.busy, bus.ps2_clk, bus.ps2_data}, 4'b1011);

        // UP: full keystroke, exact busy length and literal frame bits.
        f0 = frames.size();
        busy_cnt = 0;
        send(4'b0001, 1);
        check("start_bit_after_accept", {bus.busy, bus.ps2_clk, bus.ps2_data}, 3'b110);
        wait_idle(TOTAL + 20);
        check("up_busy_cycles", busy_cnt, 294);
        check("up_frames", frames.size() - f0, 3);
        check("up_frame0_bits", frames[f0], 11'b11000111010);
        check("up_break_parity", frames[f0+1][9], 1'b1);
        check("up_frame2_byte", frames[f0+2][8:1], 8'h1D);

        // RIGHT and LEFT: byte value and parity 0.
        f0 = frames.size();
        send(4'b0100, 1);
        wait_idle(TOTAL + 20);
        check("right_byte", frames[f0][8:1], 8'h23);
        check("right_parity", frames[f0][9], 1'b0);
        check("right_break", frames[f0+1][8:1], 8'hF0);
        f0 = frames.size();
        send(4'b1000, 1);
        wait_idle(TOTAL + 20);
        check("left_byte", frames[f0][8:1], 8'h1C);
        check("left_parity", frames[f0][9], 1'b0);

        // Non-one-hot commands are consumed silently.
        f0 = frames.size();
        busy_cnt = 0;
        send(4'b0011, 1);
        send(4'b0000, 1);
        cycles(500);
        check("bad_cmd_busy", busy_cnt, 0);
        check("bad_cmd_frames", frames.size() - f0, 0);

        // DOWN held valid: one keystroke, then re-accept on the ready cycle.
        f0 = frames.size();
        @(posedge clk);
        #1;
        bus.key_command = 4'b0010;
        bus.cmd_valid   = 1'b1;
        n = 0;
        while (!bus.busy && n < 5) begin cycles(1); n++; end
        n = 0;
        while (!bus.cmd_ready && n < TOTAL + 20) begin cycles(1); n++; end
        check("held_ready_rise", bus.cmd_ready, 1'b1);
        cycles(1);
        bus.cmd_valid = 1'b0;
        check("b2b_busy", {bus.busy, bus.ps2_data}, 2'b10);
        wait_idle(TOTAL + 20);
        check("held_frames", frames.size() - f0, 6);
        check("held_byte0", frames[f0][8:1], 8'h1B);
        check("held_byte3", frames[f0+3][8:1], 8'h1B);

        // Reset during bit 5 of the 0xF0 frame, then a clean DOWN.
        f0 = frames.size();
        send(4'b0010, 1);
        cycles(PER + 5 * 2 * CH + 2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("mid_reset_outputs", {bus.cmd_ready, bus.busy, bus.ps2_clk, bus.ps2_data}, 4'b1011);
        check("mid_reset_frames", frames.size() - f0, 1);
        f0 = frames.size();
        send(4'b0010, 1);
        wait_idle(TOTAL + 20);
        check("after_reset_frames", frames.size() - f0, 3);
        check("after_reset_byte1", frames[f0+1][8:1], 8'hF0);

        // Random commands, hold lengths and occasional resets.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3) != 0) k = 4'b0001 << $urandom_range(3);
            else k = 4'($urandom_range(15));
            cycles($urandom_range(20));
            send(k, $urandom_range(1, 3));
            if ($urandom_range(4) == 0) begin
                cycles($urandom_range(TOTAL));
                rst = 1'b1;
                cycles(1);
                rst = 1'b0;
            end
            wait_idle(TOTAL + 20);
        end

        cycles(5);
        check("leftover_bytes", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_encoder_tx.md
# ps2_key_encoder_tx

Device-side PS/2 transmitter that emulates a keyboard for the WASD direction path. It takes a one-hot direction command, maps it to the Set-2 scan code, and serializes a full keystroke on ps2_clk/ps2_data: make code, then break prefix 0xF0, then the code again. It closes the loop with the keyboard decoder and direction-mapping logic, and is used for on-board loopback and for driving the receive chain in simulation.

## Interface
- CLK_HALF, 2500: system-clock cycles per PS/2 clock half-period (10 kHz PS/2 clock at 50 MHz); must be ≥ 1.
- GAP_CYCLES, 5000: idle cycles (clk = 1, data = 1) after each byte's stop bit; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_command  in  4  one-hot direction:
  - 4'b0001 UP, scan code 0x1D (W).
  - 4'b0010 DOWN, scan code 0x1B (S).
  - 4'b0100 RIGHT, scan code 0x23 (D).
  - 4'b1000 LEFT, scan code 0x1C (A).
- cmd_valid  in  1  key_command is valid this cycle.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- ps2_clk  out  1  PS/2 clock, idle high.
- ps2_data  out  1  PS/2 data, idle high.
- busy  out  1  high from the cycle after acceptance until return to IDLE.

## Operation
- Reset values: ps2_clk = 1, ps2_data = 1, cmd_ready = 1, busy = 0, state IDLE.
- States:
  - IDLE: ps2_clk = 1, ps2_data = 1.
  - BIT_HI: ps2_clk = 1, ps2_data = current bit.
  - BIT_LO: ps2_clk = 0, ps2_data holds the current bit.
  - GAP: ps2_clk = 1, ps2_data = 1.
- Transitions:
  - IDLE → BIT_HI on a valid one-hot command.
  - BIT_HI → BIT_LO after CLK_HALF cycles.
  - BIT_LO → BIT_HI (next bit) after CLK_HALF cycles; after the 11th bit it goes to GAP instead.
  - GAP → BIT_HI (next byte) after GAP_CYCLES, or → IDLE after the third byte.
- Byte sequence: index 0 = code, 1 = 0xF0, 2 = code. The code is latched at acceptance.
- Frame is 11 bits, each presented during BIT_HI so the host samples a stable value on the falling edge:
  - start bit 0,
  - 8 data bits, LSB first,
  - odd parity (parity bit = ~^data),
  - stop bit 1.
- Non-one-hot key_command (zero or more than one bit set) with cmd_valid: the command is accepted (consumed), no frame is sent, and the block stays in IDLE.
- cmd_valid while busy is ignored. There is no queueing.

## Timing
- Acceptance at edge t → at t+1: busy = 1, cmd_ready = 0, state BIT_HI, ps2_data = 0 (start bit), ps2_clk = 1.
- One bit = 2·CLK_HALF cycles. One frame = 22·CLK_HALF cycles, then GAP_CYCLES.
- Full keystroke = 3·(22·CLK_HALF + GAP_CYCLES) cycles from t+1 until IDLE. cmd_ready rises in the IDLE cycle that follows.
- The first ps2_clk falling edge occurs CLK_HALF cycles after t+1. ps2_data changes only on the cycle entering BIT_HI.
- Counters are sized $clog2(max(CLK_HALF, GAP_CYCLES) + 1) bits. Each counter resets to 0 on every state entry, with no off-by-one: each state lasts exactly its parameter count.
- Reset mid-frame: on the next edge all outputs return to reset values. The truncated frame is abandoned and not resumed.
- A back-to-back command arriving on the same cycle cmd_ready rises is accepted. Its start bit follows after exactly one IDLE cycle.

## Structure
- Shared package ps2_pkg holds:
  - DIRECTION_UP/DOWN/RIGHT/LEFT (4'b0001/0010/0100/1000),
  - SC_W 8'h1D, SC_S 8'h1B, SC_A 8'h1C, SC_D 8'h23,
  - SC_BREAK 8'hF0,
  - the tx state enum.
- The direction and scan-code constants are shared with the receive-side mapper.
- Sub-module ps2_frame_tx serializes one byte:
  - inputs start and byte[7:0];
  - outputs done, ps2_clk, ps2_data.
  - It owns BIT_HI/BIT_LO and the bit counter.
- The top level owns IDLE/GAP, the byte index, the scan-code lookup, and the handshake.

## Test plan
All directed tests use CLK_HALF = 4, GAP_CYCLES = 10.
- UP (4'b0001) accepted → three frames:
  - 0x1D: bits 0,1,0,1,1,1,0,0,0, parity 1, stop 1;
  - 0xF0: parity 1;
  - 0x1D.
  - busy is high for exactly 3·(88+10) = 294 cycles.
- RIGHT (4'b0100) → decoded bytes 0x23 (parity 0), 0xF0, 0x23. LEFT (4'b1000) → 0x1C (parity 0). Byte values are checked by a falling-edge-sampling PS/2 receiver model.
- key_command = 4'b0011 or 4'b0000 with cmd_valid → cmd_ready stays 1, busy stays 0, ps2_clk/ps2_data stay 1 for 500 cycles.
- cmd_valid held high with DOWN while busy → exactly one keystroke (0x1B, 0xF0, 0x1B). The next keystroke starts one cycle after cmd_ready rises.
- rst asserted during bit 5 of the 0xF0 frame → next cycle ps2_clk = 1, ps2_data = 1, cmd_ready = 1, busy = 0. A new DOWN command afterwards produces a clean full sequence.
